// File: rtl/id_ex_reg_pkg.sv
// Shared pipeline encodings used by decode and the ID/EX boundary.
// Holds opcodes, ALU op codes, mux select encodings and boolean constants.
package id_ex_reg_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned RADDR_W_DEF = 5;
  localparam int unsigned ALUOP_W     = 2;
  localparam int unsigned CNT_W       = 16;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // ALU operand B select and destination register select
  localparam logic FROM_RT  = 1'b0;
  localparam logic FROM_IMM = 1'b1;
  localparam logic TO_RT    = 1'b0;
  localparam logic TO_RD    = 1'b1;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

endpackage

// File: rtl/id_ex_reg_hazard.sv
// Load-use hazard detector: purely combinational compare of the load in EX
// against the source registers of the instruction currently in ID.
module hazard_detect
  import id_ex_reg_pkg::*;
#(
  parameter int unsigned RADDR_W = RADDR_W_DEF
) (
  input  logic               ex_valid,
  input  logic               ex_mem_read,
  input  logic [RADDR_W-1:0] ex_rt,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic               id_alu_src,
  input  logic               id_mem_write,
  output logic               stall
);

  logic rs_hit;
  logic rt_hit;
  logic rt_is_src;

  // rt is only a true source for register-operand ALU ops and for stores
  always_comb begin
    rt_is_src = (id_alu_src == FROM_RT) || id_mem_write;
    rs_hit    = (ex_rt == id_rs);
    rt_hit    = (ex_rt == id_rt) && rt_is_src;
    stall     = ex_valid && ex_mem_read && (ex_rt != RADDR_W'(0)) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use stall, flush squash and a
// saturating count of inserted bubbles.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned RADDR_W = RADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_reg_dst,
  input  logic               id_alu_src,
  input  logic               id_branch,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_reg_src,
  input  logic               id_reg_write,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic [DATA_W-1:0]  id_pc4,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               flush,
  output logic               ex_reg_dst,
  output logic               ex_alu_src,
  output logic               ex_branch,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_reg_src,
  output logic               ex_reg_write,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [DATA_W-1:0]  ex_pc4,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_rt_data,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [RADDR_W-1:0] ex_rs,
  output logic [RADDR_W-1:0] ex_rt,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_valid,
  output logic               stall,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic bubble;

  hazard_detect #(
    .RADDR_W (RADDR_W)
  ) u_hazard (
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_alu_src   (id_alu_src),
    .id_mem_write (id_mem_write),
    .stall        (stall)
  );

  // flush and stall together still produce a single bubble
  always_comb begin
    bubble = flush || stall;
  end

  // Pipeline register: a bubble clears only side-effecting controls and valid
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg_dst   <= 1'b0;
      ex_alu_src   <= 1'b0;
      ex_branch    <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_reg_src   <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_alu_op    <= ALUOP_W'(0);
      ex_pc4       <= DATA_W'(0);
      ex_rs_data   <= DATA_W'(0);
      ex_rt_data   <= DATA_W'(0);
      ex_imm       <= DATA_W'(0);
      ex_rs        <= RADDR_W'(0);
      ex_rt        <= RADDR_W'(0);
      ex_rd        <= RADDR_W'(0);
      ex_valid     <= 1'b0;
    end else if (bubble) begin
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_valid     <= 1'b0;
    end else begin
      ex_reg_dst   <= id_reg_dst;
      ex_alu_src   <= id_alu_src;
      ex_branch    <= id_branch;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
      ex_reg_src   <= id_reg_src;
      ex_reg_write <= id_reg_write;
      ex_alu_op    <= id_alu_op;
      ex_pc4       <= id_pc4;
      ex_rs_data   <= id_rs_data;
      ex_rt_data   <= id_rt_data;
      ex_imm       <= id_imm;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_rd        <= id_rd;
      ex_valid     <= 1'b1;
    end
  end

  // Saturating bubble counter
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= CNT_W'(0);
    end else if (bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg: load, load-use stall, flush,
// reset priority and bubble counter saturation.
module tb_id_ex_reg;
  import id_ex_reg_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_reg_dst, id_alu_src, id_branch, id_mem_read, id_mem_write;
  logic          id_reg_src, id_reg_write;
  logic [1:0]    id_alu_op;
  logic [DW-1:0] id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          flush;
  logic          ex_reg_dst, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write;
  logic          ex_reg_src, ex_reg_write;
  logic [1:0]    ex_alu_op;
  logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
  logic          ex_valid, stall;
  logic [15:0]   bubble_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.DATA_W(DW), .RADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_src(id_reg_src),
    .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
    .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_src(ex_reg_src),
    .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
    .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .stall(stall), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_reg_dst = 1'b0; id_alu_src = 1'b0; id_branch = 1'b0; id_mem_read = 1'b0;
    id_mem_write = 1'b0; id_reg_src = 1'b0; id_reg_write = 1'b0; id_alu_op = 2'b00;
    id_pc4 = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0;
  endtask

  // Drive a load word: rt is the destination, address from rs + imm
  task automatic set_lw(input logic [AW-1:0] rs, input logic [AW-1:0] rt);
    clear_id();
    id_mem_read = 1'b1; id_reg_write = 1'b1; id_alu_src = FROM_IMM;
    id_reg_src = 1'b1; id_reg_dst = TO_RT; id_rs = rs; id_rt = rt;
    id_imm = 32'h8; id_pc4 = 32'h100;
  endtask

  task automatic set_add(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd);
    clear_id();
    id_reg_write = 1'b1; id_alu_src = FROM_RT; id_reg_dst = TO_RD;
    id_alu_op = ALUOP_RTYPE; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = 32'h11; id_rt_data = 32'h22; id_pc4 = 32'h104;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({ex_reg_dst, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write,
                             ex_reg_src, ex_reg_write, ex_alu_op, ex_valid}), 64'd0);
    chk({tag, "_data"}, 64'(|{ex_pc4, ex_rs_data, ex_rt_data, ex_imm}), 64'd0);
    chk({tag, "_addr"}, 64'({ex_rs, ex_rt, ex_rd}), 64'd0);
    chk({tag, "_cnt"}, 64'(bubble_cnt), 64'd0);
  endtask

  initial begin
    clear_id();
    flush = 1'b0;
    rst   = 1'b1;
    tick(); tick();
    // Pollute inputs to confirm reset dominates flush and pending loads
    set_lw(5'd1, 5'd2);
    flush = 1'b1;
    tick();
    chk_all_zero("reset");
    rst = 1'b0; flush = 1'b0;
    clear_id();
    #1;
    chk("reset_stall", 64'(stall), 64'd0);

    // ADDI: immediate operand path, single-cycle latency
    clear_id();
    id_alu_src = FROM_IMM; id_reg_write = 1'b1; id_reg_dst = TO_RT; id_alu_op = ALUOP_ADD;
    id_imm = 32'h0000_0010; id_rs_data = 32'h5; id_rs = 5'd1; id_rt = 5'd4; id_pc4 = 32'h4;
    tick();
    chk("addi_imm", 64'(ex_imm), 64'h10);
    chk("addi_rs_data", 64'(ex_rs_data), 64'h5);
    chk("addi_alu_src", 64'(ex_alu_src), 64'(FROM_IMM));
    chk("addi_valid", 64'(ex_valid), 64'd1);
    chk("addi_rt_pc4", 64'({ex_rt, ex_pc4}), 64'({5'd4, 32'h4}));

    // LW $2 then dependent ADD: one stall cycle, one bubble
    set_lw(5'd1, 5'd2);
    #1;
    chk("lw2_no_stall", 64'(stall), 64'd0);
    tick();
    chk("lw2_in_ex", 64'({ex_mem_read, ex_rt, ex_valid}), 64'({1'b1, 5'd2, 1'b1}));
    set_add(5'd2, 5'd3, 5'd4);
    #1;
    chk("lu_stall", 64'(stall), 64'd1);
    tick();
    chk("lu_bubble_valid", 64'(ex_valid), 64'd0);
    chk("lu_bubble_ctrl", 64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}), 64'd0);
    chk("lu_hold_rt_imm", 64'({ex_rt, ex_imm}), 64'({5'd2, 32'h8}));
    chk("lu_cnt", 64'(bubble_cnt), 64'd1);
    chk("lu_stall_clear", 64'(stall), 64'd0);
    tick();
    chk("add_enters_ex", 64'({ex_valid, ex_rs, ex_rd, ex_alu_op, ex_reg_dst}),
        64'({1'b1, 5'd2, 5'd4, ALUOP_RTYPE, TO_RD}));
    chk("add_cnt", 64'(bubble_cnt), 64'd1);

    // LW $0 then ADD from $0: never a hazard
    rst = 1'b1; tick(); rst = 1'b0;
    set_lw(5'd1, 5'd0);
    tick();
    set_add(5'd0, 5'd5, 5'd6);
    #1;
    chk("r0_no_stall", 64'(stall), 64'd0);
    tick();
    chk("r0_valid_cnt", 64'({ex_valid, bubble_cnt}), 64'({1'b1, 16'd0}));

    // LW $3 then LW using $3 as destination only
    set_lw(5'd1, 5'd3);
    tick();
    set_lw(5'd5, 5'd3);
    #1;
    chk("lw_rt_dest", 64'(stall), 64'd0);
    id_alu_src = FROM_RT;
    #1;
    chk("rt_as_src", 64'(stall), 64'd1);
    id_alu_src = FROM_IMM; id_mem_write = 1'b1; id_mem_read = 1'b0;
    #1;
    chk("sw_rt_src", 64'(stall), 64'd1);
    set_lw(5'd5, 5'd3);
    tick();
    chk("lw_lw_valid", 64'({ex_valid, bubble_cnt}), 64'({1'b1, 16'd0}));

    // flush together with stall: single bubble
    set_add(5'd3, 5'd7, 5'd8);
    flush = 1'b1;
    #1;
    chk("fs_stall", 64'(stall), 64'd1);
    tick();
    chk("fs_bubble", 64'({ex_valid, ex_reg_write, ex_mem_write}), 64'd0);
    chk("fs_cnt", 64'(bubble_cnt), 64'd1);
    flush = 1'b0;
    #1;
    chk("fs_stall_clear", 64'(stall), 64'd0);

    // SW loaded, then flushed: store squashed, data held
    clear_id();
    id_mem_write = 1'b1; id_alu_src = FROM_IMM; id_rs = 5'd9; id_rt = 5'd10;
    id_rt_data = 32'hCAFE; id_imm = 32'h20;
    tick();
    chk("sw_loaded", 64'({ex_mem_write, ex_valid, ex_rt_data}), 64'({2'b11, 32'hCAFE}));
    set_add(5'd1, 5'd2, 5'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_squash", 64'({ex_mem_write, ex_valid}), 64'd0);
    chk("flush_hold", 64'({ex_rt_data, ex_rs}), 64'({32'hCAFE, 5'd9}));
    chk("flush_cnt", 64'(bubble_cnt), 64'd2);

    // Reset mid-stall drops the pending instruction
    set_lw(5'd1, 5'd2);
    tick();
    set_add(5'd2, 5'd3, 5'd4);
    #1;
    chk("ms_stall", 64'(stall), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("ms_reset");
    chk("ms_stall_after", 64'(stall), 64'd0);
    tick();
    chk("ms_next_load", 64'({ex_valid, ex_rd, bubble_cnt}), 64'({1'b1, 5'd4, 16'd0}));

    // Saturation: drive to 16'hFFFE then three more bubbles
    flush = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
    end
    #1;
    chk("sat_pre", 64'(bubble_cnt), 64'hFFFE);
    tick();
    chk("sat_1", 64'(bubble_cnt), 64'hFFFF);
    tick(); tick();
    chk("sat_3", 64'(bubble_cnt), 64'hFFFF);
    flush = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("sat_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
